// File: rtl/csr_pkg.sv
// Shared CSR bus definitions: modify opcodes, default CSR addresses and the modify helper.
// Optional button interrupt support is enabled by defining CSR_BUTTONS_IRQ_EN.
package csr_pkg;

    typedef enum logic [1:0] {
        MOD_NONE  = 2'b00,
        MOD_WRITE = 2'b01,
        MOD_SET   = 2'b10,
        MOD_CLEAR = 2'b11
    } csr_modify_e;

    localparam logic [11:0] CSR_ADDR_UART      = 12'h7c0;
    localparam logic [11:0] CSR_ADDR_LEDS      = 12'h7c1;
    localparam logic [11:0] CSR_ADDR_BTN_STATE = 12'h7c2;
    localparam logic [11:0] CSR_ADDR_BTN_PEND  = 12'h7c3;
    localparam logic [11:0] CSR_ADDR_BTN_MASK  = 12'h7c4;

    function automatic logic [31:0] apply_modify(input logic [31:0] old_val,
                                                 input logic [31:0] wdata,
                                                 input logic [1:0]  modify);
        case (csr_modify_e'(modify))
            MOD_WRITE: apply_modify = wdata;
            MOD_SET:   apply_modify = old_val | wdata;
            MOD_CLEAR: apply_modify = old_val & ~wdata;
            default:   apply_modify = old_val;
        endcase
    endfunction

    // Rise bits live in [15:0], fall bits in [31:16]; only n of each exist.
    function automatic logic [31:0] pend_impl_mask(input int unsigned n);
        logic [15:0] half;
        half = 16'((33'd1 << n) - 33'd1);
        return {half, half};
    endfunction

endpackage

// File: rtl/csr_buttons_debounce.sv
// One button channel: 2-FF synchroniser, stability counter, debounced level and
// single-cycle rise/fall pulses coincident with the cycle the level is accepted.
module csr_buttons_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic stable,
    output logic rise,
    output logic fall
);
    localparam int unsigned      CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_reg;
    logic          stable_reg;
    logic [CW-1:0] cnt_reg;
    logic          sync_bit;
    logic          change;
    logic          accept;

    assign sync_bit = sync_reg[1];
    assign change   = (sync_bit != stable_reg);
    assign accept   = change && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg   <= '0;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync_reg <= {sync_reg[0], btn};
            if (accept) begin
                stable_reg <= sync_bit;
                cnt_reg    <= '0;
            end else if (change) begin
                cnt_reg <= cnt_reg + CW'(1);
            end else begin
                // Any return to the accepted level restarts the stability window.
                cnt_reg <= '0;
            end
        end
    end

    assign stable = stable_reg;
    assign rise   = accept & sync_bit;
    assign fall   = accept & ~sync_bit;

endmodule

// File: rtl/csr_buttons.sv
// CSR-mapped debounced push-buttons: STATE (read-only level) and PEND (sticky edges).
// Defining CSR_BUTTONS_IRQ_EN adds a MASK register and a registered level irq output.
module csr_buttons
    import csr_pkg::*;
#(
    parameter logic [11:0] BASE_ADDR       = CSR_ADDR_BTN_STATE,
    parameter int unsigned N_BUTTONS       = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 read,
    input  logic [1:0]           modify,
    input  logic [31:0]          wdata,
    input  logic [11:0]          addr,
    output logic [31:0]          rdata,
    output logic                 valid,
    input  logic [N_BUTTONS-1:0] btn
`ifdef CSR_BUTTONS_IRQ_EN
    ,
    output logic                 irq
`endif
);
    localparam logic [31:0] IMPL_MASK = pend_impl_mask(N_BUTTONS);

    logic [N_BUTTONS-1:0] stable_vec;
    logic [N_BUTTONS-1:0] rise_vec;
    logic [N_BUTTONS-1:0] fall_vec;
    logic [31:0]          state_val;
    logic [31:0]          hw_set;
    logic [31:0]          pend_reg, pend_next;
    logic [31:0]          rdata_reg, rdata_next;
    logic                 valid_reg, valid_next;
    logic                 sel_state, sel_pend;

    // The response is decoded from the address alone; the strobe carries no extra meaning.
    logic unused_read;
    assign unused_read = read;

    genvar gi;
    generate
        for (gi = 0; gi < N_BUTTONS; gi++) begin : g_btn
            csr_buttons_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .rst    (rst),
                .btn    (btn[gi]),
                .stable (stable_vec[gi]),
                .rise   (rise_vec[gi]),
                .fall   (fall_vec[gi])
            );
        end
    endgenerate

    assign sel_state = (addr == BASE_ADDR);
    assign sel_pend  = (addr == BASE_ADDR + 12'd1);

`ifdef CSR_BUTTONS_IRQ_EN
    logic        sel_mask;
    logic [31:0] mask_reg, mask_next;
    logic        irq_reg;

    assign sel_mask  = (addr == BASE_ADDR + 12'd2);
    assign mask_next = sel_mask ? (apply_modify(mask_reg, wdata, modify) & IMPL_MASK) : mask_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_reg <= '0;
            irq_reg  <= 1'b0;
        end else begin
            mask_reg <= mask_next;
            irq_reg  <= |(pend_reg & mask_reg);
        end
    end

    assign irq = irq_reg;
`endif

    always_comb begin
        state_val                 = '0;
        hw_set                    = '0;
        state_val[N_BUTTONS-1:0]  = stable_vec;
        hw_set[N_BUTTONS-1:0]     = rise_vec;
        hw_set[16 +: N_BUTTONS]   = fall_vec;
        // Hardware edges are ORed after the software update so a coincident edge survives a clear.
        pend_next = sel_pend ? apply_modify(pend_reg, wdata, modify) : pend_reg;
        pend_next = (pend_next | hw_set) & IMPL_MASK;
    end

    always_comb begin
        rdata_next = '0;
        valid_next = 1'b0;
        if (sel_state) begin
            rdata_next = state_val;
            valid_next = 1'b1;
        end
        if (sel_pend) begin
            rdata_next = pend_reg;
            valid_next = 1'b1;
        end
`ifdef CSR_BUTTONS_IRQ_EN
        if (sel_mask) begin
            rdata_next = mask_reg;
            valid_next = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_reg  <= '0;
            rdata_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            pend_reg  <= pend_next;
            rdata_reg <= rdata_next;
            valid_reg <= valid_next;
        end
    end

    assign rdata = rdata_reg;
    assign valid = valid_reg;

endmodule
